// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC register's control pins one at a
// time, reads instruction memory with a fixed latency, and hands the captured
// instruction to the decoder over a valid/ready handshake.
module fetch_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               start_zero_i,
  input  logic [ADDR_W-1:0]  pc_value_i,
  output logic               pc_inc_o,
  output logic               pc_reset_o,
  output logic               pc_write_en_o,
  output logic [ADDR_W-1:0]  pc_datain_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic               imem_rd_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] ir_o,
  output logic               ir_valid_o,
  input  logic               ir_ready_i,
  input  logic               jump_req_i,
  input  logic [ADDR_W-1:0]  jump_addr_i,
  input  logic               halt_i,
  output logic               busy_o
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StClr  = 3'd1;
  localparam logic [2:0] StAddr = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StCapt = 3'd4;
  localparam logic [2:0] StHold = 3'd5;
  localparam logic [2:0] StJump = 3'd6;

  // WAIT spans MEM_LAT-1 cycles, so the counter starts at MEM_LAT-2 and exits at 0.
  localparam logic [2:0] WaitInit = (MEM_LAT >= 2) ? 3'(MEM_LAT - 2) : 3'd0;

  logic [2:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  datain_q, datain_d;

  // Next-state and datapath update for the fetch sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    datain_d = datain_q;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = start_zero_i ? StClr : StAddr;
      end
      StClr: state_d = StAddr;
      StAddr: begin
        addr_d = pc_value_i;
        if (MEM_LAT <= 1) begin
          state_d = StCapt;
        end else begin
          cnt_d   = WaitInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) state_d = StCapt;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StCapt: begin
        ir_d    = imem_rdata_i;
        state_d = StHold;
      end
      StHold: begin
        if (ir_ready_i) begin
          if (halt_i) begin
            state_d = StIdle;
          end else if (jump_req_i) begin
            datain_d = jump_addr_i;
            state_d  = StJump;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StJump:  state_d = StAddr;
      default: state_d = StIdle;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      ir_q     <= '0;
      datain_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      datain_q <= datain_d;
    end
  end

  // Outputs decoded from state; inc/write are masked by reset so they never
  // overlap the reset pulse and no PC update leaks out of an aborted fetch.
  always_comb begin
    pc_inc_o      = (state_q == StCapt) & ~reset_i;
    pc_write_en_o = (state_q == StJump) & ~reset_i;
    pc_reset_o    = reset_i | (state_q == StClr);
    pc_datain_o   = datain_q;
    imem_rd_o     = (state_q == StAddr);
    imem_addr_o   = (state_q == StAddr) ? pc_value_i : addr_q;
    ir_o          = ir_q;
    ir_valid_o    = (state_q == StHold);
    busy_o        = (state_q != StIdle);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: two instances (MEM_LAT=1 and MEM_LAT=3), each
// with a PC register model (inc > reset > write_en) and a latency-matched memory.
module tb_fetch_ctrl;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] mem [0:65535];

  // Instance 1 (MEM_LAT=1)
  logic        start1, sz1, inc1, prst1, we1, rd1, irv1, rdy1, jmp1, halt1, busy1;
  logic [15:0] pc1, din1, addr1, rdata1, ir1, jaddr1;
  logic        ld1;
  logic [15:0] ld_val1;
  // Instance 3 (MEM_LAT=3)
  logic        start3, sz3, inc3, prst3, we3, rd3, irv3, rdy3, jmp3, halt3, busy3;
  logic [15:0] pc3, din3, addr3, rdata3, ir3, jaddr3;
  logic        ld3;
  logic [15:0] ld_val3;
  logic [15:0] p3a, p3b;

  int inc_cnt1 = 0, we_cnt1 = 0, inc_cnt3 = 0, viol = 0;

  fetch_ctrl #(.ADDR_W(16), .INSTR_W(16), .MEM_LAT(1)) u1 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .start_zero_i(sz1),
    .pc_value_i(pc1), .pc_inc_o(inc1), .pc_reset_o(prst1), .pc_write_en_o(we1),
    .pc_datain_o(din1), .imem_addr_o(addr1), .imem_rd_o(rd1), .imem_rdata_i(rdata1),
    .ir_o(ir1), .ir_valid_o(irv1), .ir_ready_i(rdy1), .jump_req_i(jmp1),
    .jump_addr_i(jaddr1), .halt_i(halt1), .busy_o(busy1)
  );

  fetch_ctrl #(.ADDR_W(16), .INSTR_W(16), .MEM_LAT(3)) u3 (
    .clk_i(clk), .reset_i(reset), .start_i(start3), .start_zero_i(sz3),
    .pc_value_i(pc3), .pc_inc_o(inc3), .pc_reset_o(prst3), .pc_write_en_o(we3),
    .pc_datain_o(din3), .imem_addr_o(addr3), .imem_rd_o(rd3), .imem_rdata_i(rdata3),
    .ir_o(ir3), .ir_valid_o(irv3), .ir_ready_i(rdy3), .jump_req_i(jmp3),
    .jump_addr_i(jaddr3), .halt_i(halt3), .busy_o(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register models plus a bench-side load port for presetting the PC.
  always @(posedge clk) begin
    if (ld1)        pc1 <= ld_val1;
    else if (inc1)  pc1 <= pc1 + 16'd1;
    else if (prst1) pc1 <= 16'd0;
    else if (we1)   pc1 <= din1;
    if (ld3)        pc3 <= ld_val3;
    else if (inc3)  pc3 <= pc3 + 16'd1;
    else if (prst3) pc3 <= 16'd0;
    else if (we3)   pc3 <= din3;
  end

  // Memories: data appears MEM_LAT cycles after the address is presented.
  always @(posedge clk) begin
    rdata1 <= mem[addr1];
    p3a    <= mem[addr3];
    p3b    <= p3a;
    rdata3 <= p3b;
  end

  // Pulse counters and mutual-exclusion monitor for the PC control pins.
  always @(posedge clk) begin
    if (inc1) inc_cnt1 <= inc_cnt1 + 1;
    if (we1)  we_cnt1  <= we_cnt1 + 1;
    if (inc3) inc_cnt3 <= inc_cnt3 + 1;
    if (($countones({inc1, prst1, we1}) > 1) || ($countones({inc3, prst3, we3}) > 1))
      viol <= viol + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({busy1, irv1, inc1, we1, rd1, prst1} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy/irv/inc/we/rd/prst=%b, want 000001",
               {busy1, irv1, inc1, we1, rd1, prst1});
    end
    n_tests++;
    if ({ir1, din1, addr1} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got ir=%h din=%h addr=%h, want all 0000", ir1, din1, addr1);
    end
    n_tests++;
    if (pc1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_pc: got %h, want 0000", pc1);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if ({prst1, busy1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: got prst/busy=%b, want 00", {prst1, busy1});
    end
  endtask

  task automatic test_basic();
    int inc0;
    mem[16'h0000] = 16'h1111;
    inc0 = inc_cnt1;
    start1 = 1'b1;
    sz1 = 1'b0;
    tick();  // cycle 1: ADDR
    start1 = 1'b0;
    n_tests++;
    if ({rd1, busy1, addr1} !== {2'b11, 16'h0000}) begin
      n_fail++;
      $display("FAIL basic_addr: got rd=%b busy=%b addr=%h, want rd=1 busy=1 addr=0000",
               rd1, busy1, addr1);
    end
    tick();  // cycle 2: CAPT
    n_tests++;
    if ({inc1, irv1, rd1} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_capt: got inc/irv/rd=%b, want 100", {inc1, irv1, rd1});
    end
    tick();  // cycle 3: HOLD
    n_tests++;
    if ({irv1, ir1, pc1} !== {1'b1, 16'h1111, 16'h0001}) begin
      n_fail++;
      $display("FAIL basic_hold: got irv=%b ir=%h pc=%h, want irv=1 ir=1111 pc=0001",
               irv1, ir1, pc1);
    end
    n_tests++;
    if (inc_cnt1 - inc0 !== 1) begin
      n_fail++;
      $display("FAIL basic_inc_count: got %0d, want 1", inc_cnt1 - inc0);
    end
    rdy1 = 1'b1;
    halt1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    halt1 = 1'b0;
    n_tests++;
    if ({busy1, irv1} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_halt: got busy/irv=%b, want 00", {busy1, irv1});
    end
  endtask

  task automatic test_stream();
    int inc0;
    int v0;
    logic [15:0] exp_ir;
    pulse_reset();
    for (int i = 0; i < 4; i++) mem[i] = 16'h00A0 + 16'(i);
    inc0 = inc_cnt1;
    v0 = viol;
    rdy1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();  // cycle 3: first HOLD
    for (int k = 0; k < 4; k++) begin
      exp_ir = 16'h00A0 + 16'(k);
      n_tests++;
      if ({irv1, ir1} !== {1'b1, exp_ir}) begin
        n_fail++;
        $display("FAIL stream_ir%0d: got irv=%b ir=%h, want irv=1 ir=%h", k, irv1, ir1, exp_ir);
      end
      if (k == 3) begin
        halt1 = 1'b1;
        tick();
      end else begin
        tick();
        tick();
        tick();
      end
    end
    halt1 = 1'b0;
    rdy1 = 1'b0;
    n_tests++;
    if ({busy1, pc1} !== {1'b0, 16'h0004}) begin
      n_fail++;
      $display("FAIL stream_end: got busy=%b pc=%h, want busy=0 pc=0004", busy1, pc1);
    end
    n_tests++;
    if (inc_cnt1 - inc0 !== 4) begin
      n_fail++;
      $display("FAIL stream_inc_count: got %0d, want 4", inc_cnt1 - inc0);
    end
    n_tests++;
    if (viol !== v0) begin
      n_fail++;
      $display("FAIL stream_exclusive: got %0d overlaps, want 0", viol - v0);
    end
  endtask

  task automatic test_stall();
    pulse_reset();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();  // HOLD with ir=0xA0, pc=1
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if ({irv1, rd1, ir1, pc1} !== {2'b10, 16'h00A0, 16'h0001}) begin
        n_fail++;
        $display("FAIL stall_c%0d: got irv=%b rd=%b ir=%h pc=%h, want irv=1 rd=0 ir=00a0 pc=0001",
                 c, irv1, rd1, ir1, pc1);
      end
      tick();
    end
  endtask

  task automatic test_jump();
    int we0;
    mem[16'h0040] = 16'hBEEF;
    we0 = we_cnt1;
    rdy1 = 1'b1;
    jmp1 = 1'b1;
    jaddr1 = 16'h0040;
    tick();  // JUMP
    rdy1 = 1'b0;
    jmp1 = 1'b0;
    jaddr1 = 16'h0000;
    n_tests++;
    if ({we1, inc1, din1} !== {2'b10, 16'h0040}) begin
      n_fail++;
      $display("FAIL jump_pulse: got we=%b inc=%b din=%h, want we=1 inc=0 din=0040",
               we1, inc1, din1);
    end
    tick();  // ADDR
    n_tests++;
    if ({rd1, addr1, pc1} !== {1'b1, 16'h0040, 16'h0040}) begin
      n_fail++;
      $display("FAIL jump_addr: got rd=%b addr=%h pc=%h, want rd=1 addr=0040 pc=0040",
               rd1, addr1, pc1);
    end
    tick();
    tick();  // HOLD, MEM_LAT+3 after handshake
    n_tests++;
    if ({irv1, ir1} !== {1'b1, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL jump_ir: got irv=%b ir=%h, want irv=1 ir=beef", irv1, ir1);
    end
    n_tests++;
    if (we_cnt1 - we0 !== 1) begin
      n_fail++;
      $display("FAIL jump_we_count: got %0d, want 1", we_cnt1 - we0);
    end
    rdy1 = 1'b1;
    halt1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    halt1 = 1'b0;
  endtask

  task automatic test_wrap_halt();
    int we0;
    pulse_reset();
    mem[16'hFFFF] = 16'h7777;
    ld_val1 = 16'hFFFF;
    ld1 = 1'b1;
    tick();
    ld1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_tests++;
    if ({rd1, addr1} !== {1'b1, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL wrap_addr: got rd=%b addr=%h, want rd=1 addr=ffff", rd1, addr1);
    end
    tick();
    tick();
    n_tests++;
    if ({irv1, ir1, pc1} !== {1'b1, 16'h7777, 16'h0000}) begin
      n_fail++;
      $display("FAIL wrap_hold: got irv=%b ir=%h pc=%h, want irv=1 ir=7777 pc=0000",
               irv1, ir1, pc1);
    end
    we0 = we_cnt1;
    rdy1 = 1'b1;
    halt1 = 1'b1;
    jmp1 = 1'b1;
    jaddr1 = 16'h1234;
    tick();
    rdy1 = 1'b0;
    halt1 = 1'b0;
    jmp1 = 1'b0;
    n_tests++;
    if ({busy1, irv1, we1} !== 3'b000) begin
      n_fail++;
      $display("FAIL halt_prio: got busy/irv/we=%b, want 000", {busy1, irv1, we1});
    end
    tick();
    n_tests++;
    if ((we_cnt1 - we0 !== 0) || (pc1 !== 16'h0000)) begin
      n_fail++;
      $display("FAIL halt_no_jump: got we pulses=%0d pc=%h, want 0 and 0000",
               we_cnt1 - we0, pc1);
    end
  endtask

  task automatic test_lat3_zero();
    int inc0;
    mem[16'h0000] = 16'h3333;
    ld_val3 = 16'h1234;
    ld3 = 1'b1;
    tick();
    ld3 = 1'b0;
    start3 = 1'b1;
    sz3 = 1'b1;
    tick();  // cycle 1: CLR
    start3 = 1'b0;
    sz3 = 1'b0;
    n_tests++;
    if ({prst3, rd3, inc3, busy3} !== 4'b1001) begin
      n_fail++;
      $display("FAIL lat3_clr: got prst/rd/inc/busy=%b, want 1001", {prst3, rd3, inc3, busy3});
    end
    tick();  // cycle 2: ADDR
    n_tests++;
    if ({rd3, addr3, pc3} !== {1'b1, 16'h0000, 16'h0000}) begin
      n_fail++;
      $display("FAIL lat3_addr: got rd=%b addr=%h pc=%h, want rd=1 addr=0000 pc=0000",
               rd3, addr3, pc3);
    end
    tick();  // cycle 3: WAIT
    n_tests++;
    if ({rd3, busy3, addr3} !== {2'b01, 16'h0000}) begin
      n_fail++;
      $display("FAIL lat3_wait: got rd=%b busy=%b addr=%h, want rd=0 busy=1 addr=0000",
               rd3, busy3, addr3);
    end
    tick();
    tick();  // cycle 5: CAPT
    n_tests++;
    if ({inc3, irv3} !== 2'b10) begin
      n_fail++;
      $display("FAIL lat3_capt: got inc/irv=%b, want 10", {inc3, irv3});
    end
    tick();  // cycle 6: HOLD
    n_tests++;
    if ({irv3, ir3} !== {1'b1, 16'h3333}) begin
      n_fail++;
      $display("FAIL lat3_hold: got irv=%b ir=%h, want irv=1 ir=3333", irv3, ir3);
    end
    inc0 = inc_cnt3;
    rdy3 = 1'b1;
    tick();  // ADDR
    rdy3 = 1'b0;
    tick();  // WAIT
    reset = 1'b1;
    tick();
    n_tests++;
    if ({busy3, irv3, inc3, prst3} !== 4'b0001) begin
      n_fail++;
      $display("FAIL lat3_reset: got busy/irv/inc/prst=%b, want 0001",
               {busy3, irv3, inc3, prst3});
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if ({busy3, pc3} !== {1'b0, 16'h0000} || (inc_cnt3 - inc0 !== 0)) begin
      n_fail++;
      $display("FAIL lat3_after_reset: got busy=%b pc=%h inc pulses=%0d, want 0 0000 0",
               busy3, pc3, inc_cnt3 - inc0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    reset = 1'b1;
    {start1, sz1, rdy1, jmp1, halt1, ld1} = '0;
    {start3, sz3, rdy3, jmp3, halt3, ld3} = '0;
    jaddr1 = '0;
    jaddr3 = '0;
    ld_val1 = '0;
    ld_val3 = '0;
    pc1 = '0;
    pc3 = '0;
    test_reset();
    test_basic();
    test_stream();
    test_stall();
    test_jump();
    test_wrap_halt();
    test_lat3_zero();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
